lsq_ring: RTL and testbench

- Parametrised circular load/store queue for the Tomasulo back end.
- Accepts load/store entries from dispatch in program order, snoops the CDB for pending address/data operands, and issues memory accesses strictly in order from the head.
- Stores write memory only after the ROB commits them; load results return to the ROB/CDB with the entry's ROB tag.
- Adds over the previous queue: configurable depth and widths, full/count status, commit gating and flush.

---
 rtl/lsq_ring.sv | 218 +++++++++++++++++++++
 tb/tb_lsq_ring.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_ring.sv
// Circular load/store queue: in-order dispatch, CDB operand snooping, commit-gated
// stores and strictly in-order memory issue from the head.
module lsq_ring #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_en,
  input  logic                     issue_is_store,
  input  logic [TAG_W-1:0]         issue_rob_tag,
  input  logic [TAG_W-1:0]         addr_tag,
  input  logic                     addr_ready,
  input  logic [ADDR_W-1:0]        addr_val,
  input  logic [TAG_W-1:0]         data_tag,
  input  logic                     data_ready,
  input  logic [DATA_W-1:0]        data_val,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [DATA_W-1:0]        cdb_data,
  input  logic                     commit_valid,
  input  logic [TAG_W-1:0]         commit_tag,
  input  logic                     flush,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_read_val,
  output logic                     lsu_done,
  output logic [TAG_W-1:0]         lsu_tag,
  output logic [DATA_W-1:0]        lsu_val,
  output logic                     fsm_state
);

  // Memory handshake: mem_req rises with a stable payload (mem_we, mem_addr,
  // mem_data) and holds it until the cycle mem_ack is sampled high; that edge
  // completes the access and mem_req drops.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              valid;
    logic              is_store;
    logic [TAG_W-1:0]  rob_tag;
    logic              a_rdy;
    logic [TAG_W-1:0]  a_tag;
    logic [ADDR_W-1:0] a_val;
    logic              d_rdy;
    logic [TAG_W-1:0]  d_tag;
    logic [DATA_W-1:0] d_val;
    logic              committed;
  } entry_t;

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  entry_t           ent_q [DEPTH];
  entry_t           head_ent;
  entry_t           new_ent;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  state_t           state_q;
  state_t           state_d;
  logic             head_elig;
  logic             enq;
  logic             start_req;
  logic             pop;

  assign head_ent  = ent_q[head_q];
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign fsm_state = state_q;
  assign enq       = issue_en && !full && !flush;
  assign head_elig = head_ent.valid && head_ent.a_rdy &&
                     (!head_ent.is_store || (head_ent.d_rdy && head_ent.committed));

  always_comb begin
    state_d   = state_q;
    start_req = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (head_elig) begin
          start_req = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
    if (flush) begin
      state_d   = S_IDLE;
      start_req = 1'b0;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // New entry, with operands forwarded from the CDB broadcast of the same cycle.
  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.is_store  = issue_is_store;
    new_ent.rob_tag   = issue_rob_tag;
    new_ent.a_tag     = addr_tag;
    new_ent.a_rdy     = addr_ready;
    new_ent.a_val     = addr_val;
    new_ent.d_tag     = data_tag;
    new_ent.d_rdy     = data_ready;
    new_ent.d_val     = data_val;
    new_ent.committed = 1'b0;
    if (!addr_ready && cdb_valid && (cdb_tag == addr_tag)) begin
      new_ent.a_rdy = 1'b1;
      new_ent.a_val = ADDR_W'(cdb_data);
    end
    if (!data_ready && cdb_valid && (cdb_tag == data_tag)) begin
      new_ent.d_rdy = 1'b1;
      new_ent.d_val = cdb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid) begin
          if (cdb_valid && !ent_q[i].a_rdy && (ent_q[i].a_tag == cdb_tag)) begin
            ent_q[i].a_rdy <= 1'b1;
            ent_q[i].a_val <= ADDR_W'(cdb_data);
          end
          if (cdb_valid && ent_q[i].is_store && !ent_q[i].d_rdy &&
              (ent_q[i].d_tag == cdb_tag)) begin
            ent_q[i].d_rdy <= 1'b1;
            ent_q[i].d_val <= cdb_data;
          end
          if (commit_valid && ent_q[i].is_store && (ent_q[i].rob_tag == commit_tag))
            ent_q[i].committed <= 1'b1;
          if (pop && (PTR_W'(i) == head_q))
            ent_q[i].valid <= 1'b0;
        end
        // The tail slot is never valid while enqueue is allowed, so this cannot clash.
        if (enq && (PTR_W'(i) == tail_q))
          ent_q[i] <= new_ent;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + PTR_W'(1);
      if (pop) head_q <= head_q + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      lsu_done <= 1'b0;
      lsu_tag  <= '0;
      lsu_val  <= '0;
    end else if (flush) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      lsu_done <= 1'b0;
    end else begin
      lsu_done <= 1'b0;
      if (start_req) begin
        mem_req  <= 1'b1;
        mem_we   <= head_ent.is_store;
        mem_addr <= head_ent.a_val;
        mem_data <= head_ent.is_store ? head_ent.d_val : '0;
      end
      if (pop) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (!head_ent.is_store) begin
          lsu_done <= 1'b1;
          lsu_tag  <= head_ent.rob_tag;
          lsu_val  <= mem_read_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsq_ring.sv
// Bench for lsq_ring: directed scenarios plus a randomized run checked against
// an operation-level queue model.
module tb_lsq_ring;
  localparam int DEPTH = 8, TAG_W = 5, DATA_W = 32, ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic issue_en, issue_is_store, addr_ready, data_ready;
  logic [TAG_W-1:0] issue_rob_tag, addr_tag, data_tag, cdb_tag, commit_tag, lsu_tag;
  logic [ADDR_W-1:0] addr_val, mem_addr;
  logic [DATA_W-1:0] data_val, cdb_data, mem_data, mem_read_val, lsu_val;
  logic full, cdb_valid, commit_valid, flush, mem_req, mem_we, mem_ack, lsu_done, fsm_state;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit st; logic [4:0] tag;
    bit ar; logic [4:0] at; logic [31:0] av;
    bit dr; logic [4:0] dt; logic [31:0] dv;
    bit cm;
  } op_t;

  always #5 clk = ~clk;

  lsq_ring #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .issue_is_store(issue_is_store),
    .issue_rob_tag(issue_rob_tag), .addr_tag(addr_tag), .addr_ready(addr_ready),
    .addr_val(addr_val), .data_tag(data_tag), .data_ready(data_ready), .data_val(data_val),
    .full(full), .count(count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .flush(flush), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .mem_read_val(mem_read_val), .lsu_done(lsu_done), .lsu_tag(lsu_tag), .lsu_val(lsu_val),
    .fsm_state(fsm_state)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    issue_en = 0; issue_is_store = 0; issue_rob_tag = '0; addr_tag = '0; addr_ready = 0;
    addr_val = '0; data_tag = '0; data_ready = 0; data_val = '0; cdb_valid = 0; cdb_tag = '0;
    cdb_data = '0; commit_valid = 0; commit_tag = '0; flush = 0; mem_ack = 0; mem_read_val = '0;
  endtask

  task automatic drive_issue(input bit st, input logic [4:0] rt, input logic [4:0] at,
                             input bit ar, input logic [31:0] av, input logic [4:0] dt,
                             input bit dr, input logic [31:0] dv);
    issue_en = 1; issue_is_store = st; issue_rob_tag = rt; addr_tag = at; addr_ready = ar;
    addr_val = av; data_tag = dt; data_ready = dr; data_val = dv;
  endtask

  task automatic drive_cdb(input logic [4:0] t, input logic [31:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
  endtask

  // Waits a bounded number of cycles for mem_req; returns at a negedge.
  task automatic wait_req(output bit ok);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_req) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic ack_once(input logic [31:0] rd);
    mem_ack = 1; mem_read_val = rd;
    tick();
    mem_ack = 0; mem_read_val = '0;
  endtask

  function automatic bit elig(op_t o);
    return o.ar && (!o.st || (o.dr && o.cm));
  endfunction

  task automatic test_reset();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full); end
    n_checks++; if ({mem_req, mem_we, lsu_done} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %03b expected 000", {mem_req, mem_we, lsu_done}); end
    n_checks++; if (mem_addr !== 32'd0 || mem_data !== 32'd0) begin n_fail++; $display("FAIL reset_mem_payload: got %0h/%0h expected 0/0", mem_addr, mem_data); end
    n_checks++; if (lsu_tag !== 5'd0 || lsu_val !== 32'd0) begin n_fail++; $display("FAIL reset_lsu: got %0h/%0h expected 0/0", lsu_tag, lsu_val); end
    n_checks++; if (fsm_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %0b expected 0", fsm_state); end
  endtask

  task automatic test_load_basic();
    drive_issue(0, 5'd3, 5'd0, 1, 32'h100, 5'd0, 0, 32'd0);
    tick(); clear_inputs();
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL load_count1: got %0d expected 1", count); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL load_req_early: got %0b expected 0", mem_req); end
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || mem_data !== 32'd0) begin
      n_fail++; $display("FAIL load_req: got req=%0b we=%0b addr=%0h data=%0h expected 1 0 100 0", mem_req, mem_we, mem_addr, mem_data); end
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL load_req_hold: got req=%0b addr=%0h expected 1 100", mem_req, mem_addr); end
    ack_once(32'hDEADBEEF);
    n_checks++; if (mem_req !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL load_after_ack: got req=%0b count=%0d expected 0 0", mem_req, count); end
    n_checks++; if (lsu_done !== 1'b1 || lsu_tag !== 5'd3 || lsu_val !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_lsu: got done=%0b tag=%0d val=%0h expected 1 3 deadbeef", lsu_done, lsu_tag, lsu_val); end
    tick();
    n_checks++; if (lsu_done !== 1'b0) begin n_fail++; $display("FAIL load_lsu_pulse: got %0b expected 0", lsu_done); end
  endtask

  task automatic test_store_commit();
    int early;
    bit ok;
    drive_issue(1, 5'd4, 5'd7, 0, 32'd0, 5'd0, 1, 32'h55);
    tick(); clear_inputs();
    drive_cdb(5'd7, 32'h200);
    tick(); clear_inputs();
    early = 0;
    for (int k = 0; k < 10; k++) begin if (mem_req) early++; tick(); end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL store_uncommitted_req: got %0d request cycles expected 0", early); end
    commit_valid = 1; commit_tag = 5'd4;
    tick(); clear_inputs();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL store_commit_latency: got %0b expected 0", mem_req); end
    tick();
    wait_req(ok);
    n_checks++; if (!ok || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_data !== 32'h55) begin
      n_fail++; $display("FAIL store_req: got req=%0b we=%0b addr=%0h data=%0h expected 1 1 200 55", mem_req, mem_we, mem_addr, mem_data); end
    ack_once(32'hFFFF);
    n_checks++; if (lsu_done !== 1'b0 || count !== 4'd0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL store_after_ack: got done=%0b count=%0d req=%0b expected 0 0 0", lsu_done, count, mem_req); end
    tick();
    n_checks++; if (lsu_done !== 1'b0) begin n_fail++; $display("FAIL store_no_lsu: got %0b expected 0", lsu_done); end
  endtask

  task automatic test_forwarding();
    drive_issue(0, 5'd5, 5'd9, 0, 32'h0, 5'd0, 0, 32'd0);
    drive_cdb(5'd9, 32'h40);
    tick(); clear_inputs();
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL fwd_req: got req=%0b addr=%0h expected 1 40", mem_req, mem_addr); end
    ack_once(32'h1234_5678);
    n_checks++; if (lsu_done !== 1'b1 || lsu_tag !== 5'd5 || lsu_val !== 32'h1234_5678) begin
      n_fail++; $display("FAIL fwd_lsu: got done=%0b tag=%0d val=%0h expected 1 5 12345678", lsu_done, lsu_tag, lsu_val); end
    tick();
  endtask

  task automatic test_full_wrap();
    bit ok;
    for (int i = 0; i < 8; i++) begin
      drive_issue(0, 5'(i), 5'(16 + i), 0, 32'd0, 5'd0, 0, 32'd0);
      tick();
    end
    clear_inputs();
    n_checks++; if (full !== 1'b1 || count !== 4'd8) begin n_fail++; $display("FAIL full_set: got full=%0b count=%0d expected 1 8", full, count); end
    drive_issue(0, 5'd8, 5'd0, 1, 32'h9999, 5'd0, 0, 32'd0);
    tick(); clear_inputs();
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_refuse: got count=%0d expected 8", count); end
    for (int i = 0; i < 8; i++) begin
      drive_cdb(5'(16 + i), 32'h1000 + 32'(i * 16));
      tick(); clear_inputs();
      wait_req(ok);
      n_checks++; if (!ok || mem_we !== 1'b0 || mem_addr !== 32'h1000 + 32'(i * 16)) begin
        n_fail++; $display("FAIL full_drain_req%0d: got req=%0b addr=%0h expected 1 %0h", i, mem_req, mem_addr, 32'h1000 + 32'(i * 16)); end
      // Enqueue attempted on the pop cycle while full must still be refused.
      if (i == 0) drive_issue(0, 5'd8, 5'd0, 1, 32'h9999, 5'd0, 0, 32'd0);
      ack_once(32'(i) + 32'hA0);
      clear_inputs();
      n_checks++; if (count !== 4'(7 - i) || lsu_done !== 1'b1 || lsu_tag !== 5'(i) || lsu_val !== 32'(i) + 32'hA0) begin
        n_fail++; $display("FAIL full_drain_ack%0d: got count=%0d done=%0b tag=%0d val=%0h expected %0d 1 %0d %0h",
                           i, count, lsu_done, lsu_tag, lsu_val, 7 - i, i, 32'(i) + 32'hA0); end
      if (i == 0) begin
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_clear: got %0b expected 0", full); end
      end
    end
    tick(); tick();
    n_checks++; if (mem_req !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL full_empty: got req=%0b count=%0d expected 0 0", mem_req, count); end
  endtask

  task automatic test_order();
    int early;
    bit ok;
    drive_issue(1, 5'd10, 5'd0, 1, 32'h300, 5'd0, 1, 32'h77);
    tick();
    drive_issue(0, 5'd11, 5'd0, 1, 32'h400, 5'd0, 0, 32'd0);
    tick(); clear_inputs();
    early = 0;
    for (int k = 0; k < 6; k++) begin if (mem_req) early++; tick(); end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL order_blocked: got %0d request cycles expected 0", early); end
    commit_valid = 1; commit_tag = 5'd10;
    tick(); clear_inputs();
    wait_req(ok);
    n_checks++; if (!ok || mem_we !== 1'b1 || mem_addr !== 32'h300 || mem_data !== 32'h77) begin
      n_fail++; $display("FAIL order_store_first: got we=%0b addr=%0h data=%0h expected 1 300 77", mem_we, mem_addr, mem_data); end
    ack_once(32'h0);
    n_checks++; if (lsu_done !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL order_gap: got done=%0b req=%0b expected 0 0", lsu_done, mem_req); end
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h400) begin
      n_fail++; $display("FAIL order_load_second: got req=%0b we=%0b addr=%0h expected 1 0 400", mem_req, mem_we, mem_addr); end
    ack_once(32'hCAFE);
    n_checks++; if (lsu_done !== 1'b1 || lsu_tag !== 5'd11 || lsu_val !== 32'hCAFE) begin
      n_fail++; $display("FAIL order_lsu: got done=%0b tag=%0d val=%0h expected 1 11 cafe", lsu_done, lsu_tag, lsu_val); end
    tick();
  endtask

  task automatic test_flush();
    drive_issue(0, 5'd12, 5'd0, 1, 32'h500, 5'd0, 0, 32'd0);
    tick(); clear_inputs();
    tick();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_pre_req: got %0b expected 1", mem_req); end
    flush = 1; mem_ack = 1; mem_read_val = 32'hBAD;
    drive_issue(0, 5'd14, 5'd0, 1, 32'h700, 5'd0, 0, 32'd0);
    tick(); clear_inputs();
    n_checks++; if (mem_req !== 1'b0 || count !== 4'd0 || lsu_done !== 1'b0 || fsm_state !== 1'b0) begin
      n_fail++; $display("FAIL flush_state: got req=%0b count=%0d done=%0b st=%0b expected 0 0 0 0", mem_req, count, lsu_done, fsm_state); end
    tick();
    n_checks++; if (lsu_done !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_quiet: got done=%0b req=%0b expected 0 0", lsu_done, mem_req); end
    drive_issue(0, 5'd13, 5'd0, 1, 32'h600, 5'd0, 0, 32'd0);
    tick(); clear_inputs();
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL flush_reenq: got count=%0d expected 1", count); end
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin n_fail++; $display("FAIL flush_next_req: got req=%0b addr=%0h expected 1 600", mem_req, mem_addr); end
    ack_once(32'h66);
    n_checks++; if (lsu_done !== 1'b1 || lsu_tag !== 5'd13) begin n_fail++; $display("FAIL flush_next_lsu: got done=%0b tag=%0d expected 1 13", lsu_done, lsu_tag); end
    tick();
  endtask

  task automatic test_async_reset();
    drive_issue(0, 5'd1, 5'd0, 1, 32'h800, 5'd0, 0, 32'd0);
    tick(); clear_inputs();
    tick();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL arst_pre_req: got %0b expected 1", mem_req); end
    #2 rst_n = 0;
    #1;
    n_checks++; if (mem_req !== 1'b0 || count !== 4'd0 || fsm_state !== 1'b0) begin
      n_fail++; $display("FAIL arst_drop: got req=%0b count=%0d st=%0b expected 0 0 0", mem_req, count, fsm_state); end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    op_t mq[$];
    op_t nw;
    op_t h;
    bit exp_done = 0;
    logic [4:0] exp_tag = '0;
    logic [31:0] exp_val = '0;
    bit req_seen = 0;
    bit stall_reported = 0;
    bit do_enq;
    int stall = 0;
    int rt = 0;
    int ci;
    clear_inputs();
    flush = 1;
    tick(); clear_inputs();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      n_checks++; if (count !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, count, mq.size()); end
      n_checks++; if (full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full@%0d: got %0b expected %0b", cyc, full, mq.size() == DEPTH); end
      n_checks++; if (lsu_done !== exp_done) begin n_fail++; $display("FAIL rnd_lsu_done@%0d: got %0b expected %0b", cyc, lsu_done, exp_done); end
      if (exp_done) begin
        n_checks++; if (lsu_tag !== exp_tag || lsu_val !== exp_val) begin
          n_fail++; $display("FAIL rnd_lsu_result@%0d: got tag=%0d val=%0h expected %0d %0h", cyc, lsu_tag, lsu_val, exp_tag, exp_val); end
      end
      if (mem_req && !req_seen) begin
        req_seen = 1;
        n_checks++;
        if (mq.size() == 0) begin
          n_fail++; $display("FAIL rnd_req_empty@%0d: got req with empty model expected no req", cyc);
        end else if (!elig(mq[0]) || mem_we !== mq[0].st || mem_addr !== mq[0].av ||
                     mem_data !== (mq[0].st ? mq[0].dv : 32'd0)) begin
          n_fail++; $display("FAIL rnd_req@%0d: got we=%0b addr=%0h data=%0h expected we=%0b addr=%0h data=%0h eligible=%0b",
                             cyc, mem_we, mem_addr, mem_data, mq[0].st, mq[0].av, mq[0].st ? mq[0].dv : 32'd0, elig(mq[0]));
        end
      end
      if (!mem_req && mq.size() > 0 && elig(mq[0])) stall++;
      else stall = 0;
      if (stall >= 2 && !stall_reported) begin
        stall_reported = 1; n_checks++; n_fail++;
        $display("FAIL rnd_stall@%0d: got no request expected request for eligible head tag %0d", cyc, mq[0].tag);
      end

      clear_inputs();
      flush = ($urandom_range(0, 199) == 0);
      foreach (mq[j]) if (mq[j].st && mq[j].cm) flush = 0;
      mem_ack = mem_req && req_seen && ($urandom_range(0, 2) == 0);
      mem_read_val = $urandom;
      nw.st = 1'($urandom_range(0, 1)); nw.tag = 5'(rt);
      nw.ar = 1'($urandom_range(0, 1)); nw.at = 5'(16 + $urandom_range(0, 7)); nw.av = $urandom;
      nw.dr = 1'($urandom_range(0, 1)); nw.dt = 5'(16 + $urandom_range(0, 7)); nw.dv = $urandom;
      nw.cm = 0;
      if ($urandom_range(0, 2) != 0) drive_issue(nw.st, nw.tag, nw.at, nw.ar, nw.av, nw.dt, nw.dr, nw.dv);
      if ($urandom_range(0, 1) == 1) drive_cdb(5'(16 + $urandom_range(0, 7)), $urandom);
      ci = -1;
      if ($urandom_range(0, 2) == 0)
        for (int j = 0; j < mq.size(); j++) if (mq[j].st && !mq[j].cm) begin ci = j; break; end
      if (ci >= 0) begin commit_valid = 1; commit_tag = mq[ci].tag; end

      if (flush) begin
        mq.delete(); exp_done = 0; req_seen = 0; stall = 0;
      end else begin
        do_enq = issue_en && (mq.size() < DEPTH);
        if (cdb_valid) begin
          foreach (mq[j]) begin
            if (!mq[j].ar && mq[j].at == cdb_tag) begin mq[j].ar = 1; mq[j].av = cdb_data; end
            if (mq[j].st && !mq[j].dr && mq[j].dt == cdb_tag) begin mq[j].dr = 1; mq[j].dv = cdb_data; end
          end
          if (!nw.ar && nw.at == cdb_tag) begin nw.ar = 1; nw.av = cdb_data; end
          if (!nw.dr && nw.dt == cdb_tag) begin nw.dr = 1; nw.dv = cdb_data; end
        end
        if (ci >= 0) mq[ci].cm = 1;
        exp_done = 0;
        if (mem_ack) begin
          h = mq.pop_front();
          req_seen = 0;
          if (!h.st) begin exp_done = 1; exp_tag = h.tag; exp_val = mem_read_val; end
        end
        if (do_enq) begin mq.push_back(nw); rt = (rt + 1) % 16; end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1;
    tick();
    test_reset();
    test_load_basic();
    test_store_commit();
    test_forwarding();
    test_full_wrap();
    test_order();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
